seg7_scan_mux: RTL and testbench



---
 rtl/seg7_scan_mux.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_mux
//  Purpose  : Drives an N-digit multiplexed common-anode seven-segment display.
//             The prescaler sets how many clocks each digit slot lasts. At the
//             end of every frame the inputs are copied into shadow registers,
//             so a frame never shows a mix of old and new values. Each digit
//             has a decimal point and a blank bit. A PWM brightness control
//             keeps a digit lit for the first 'bright' clocks of its slot.
//             frame_start pulses on the first output clock of every frame.
//  Ports    : clk         - system clock, rising edge
//             rst_n       - synchronous reset, active-low
//             data        - 4*DIGITS hex nibbles, digit 0 in data[3:0]
//             dp          - per-digit decimal point, 1 = lit
//             blank       - per-digit blank, 1 = dark
//             bright      - on-clocks per slot (0 = dark, >=PRESCALE = full)
//             an          - anodes, active-low, one-hot-low while lit
//             cat         - segments {A,B,C,D,E,F,G,P}, active-low
//             frame_start - one-clock pulse at the start of each frame
//  Options  : SEG7_LZB_EN - leading-zero blanking on the shadow contents
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
    parameter  int DIGITS   = 4,
    parameter  int PRESCALE = 1,
    localparam int BW       = $clog2(PRESCALE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [BW-1:0]         bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            cat,
    output logic                  frame_start
);

    localparam int c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    // Active-low hex font with P off (bit 0 set).
    function automatic logic [7:0] f_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h03;
            4'h1: seg = 8'h9F;
            4'h2: seg = 8'h25;
            4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h49;
            4'h6: seg = 8'h41;
            4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01;
            4'h9: seg = 8'h09;
            4'hA: seg = 8'h11;
            4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63;
            4'hD: seg = 8'h85;
            4'hE: seg = 8'h61;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_data;
    logic [DIGITS-1:0]    r_dp;
    logic [DIGITS-1:0]    r_blank;
    logic [BW-1:0]        r_bright;

    logic                 w_tick;
    logic                 w_frame_end;
    logic [DIGITS-1:0]    w_sup;
    logic [3:0]           w_nib;
    logic                 w_dp_sel;
    logic                 w_blank_sel;
    logic [DIGITS-1:0]    w_an_sel;
    logic                 w_lit;
    logic [7:0]           w_seg;

    assign w_tick      = (r_cnt == c_cnt_last);
    assign w_frame_end = w_tick && (r_idx == c_idx_last);

`ifdef SEG7_LZB_EN
    // Suppression runs from the top digit down and stops at the first digit
    // that is nonzero or has its point lit. Digit 0 is never considered.
    logic w_lzb_run;
    always_comb begin
        w_sup     = '0;
        w_lzb_run = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (w_lzb_run && (r_data[4*k +: 4] == 4'h0) && !r_dp[k]) begin
                w_sup[k] = 1'b1;
            end else begin
                w_lzb_run = 1'b0;
            end
        end
    end
`else
    assign w_sup = '0;
`endif

    // Select the current digit's shadow fields. The compare against every
    // legal index means an out-of-range idx could never select anything.
    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b1;
        w_an_sel    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_nib       = r_data[4*k +: 4];
                w_dp_sel    = r_dp[k];
                w_blank_sel = r_blank[k] | w_sup[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    // PWM: the digit is on for the first r_bright clocks of its slot.
    assign w_lit = !w_blank_sel && (BW'(r_cnt) < r_bright);
    assign w_seg = f_decode(w_nib);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_dp        <= '0;
            r_blank     <= '1;
            r_bright    <= '0;
            an          <= '1;
            cat         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            // The shadow loads on the last clock of the frame, so the new
            // contents take effect exactly at the next slot 0.
            if (w_frame_end) begin
                r_data   <= data;
                r_dp     <= dp;
                r_blank  <= blank;
                r_bright <= bright;
            end
            an          <= w_lit ? w_an_sel : '1;
            cat         <= w_lit ? {w_seg[7:1], ~w_dp_sel} : 8'hFF;
            frame_start <= (r_idx == '0) && (r_cnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_mux
//  Purpose  : Directed bench for seg7_scan_mux. It uses one instance with
//             DIGITS=4, PRESCALE=4 and one with DIGITS=6, PRESCALE=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DIGITS=4, PRESCALE=4, BW=3
    logic        rst_n4;
    logic [15:0] data4;
    logic [3:0]  dp4;
    logic [3:0]  blank4;
    logic [2:0]  bright4;
    logic [3:0]  an4;
    logic [7:0]  cat4;
    logic        fs4;

    // Instance B: DIGITS=6, PRESCALE=1, BW=1
    logic        rst_n6;
    logic [23:0] data6;
    logic [5:0]  dp6;
    logic [5:0]  blank6;
    logic [0:0]  bright6;
    logic [5:0]  an6;
    logic [7:0]  cat6;
    logic        fs6;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_mux #(.DIGITS(4), .PRESCALE(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n4),
        .data        (data4),
        .dp          (dp4),
        .blank       (blank4),
        .bright      (bright4),
        .an          (an4),
        .cat         (cat4),
        .frame_start (fs4)
    );

    seg7_scan_mux #(.DIGITS(6), .PRESCALE(1)) u_dut6 (
        .clk         (clk),
        .rst_n       (rst_n6),
        .data        (data6),
        .dp          (dp6),
        .blank       (blank6),
        .bright      (bright6),
        .an          (an6),
        .cat         (cat6),
        .frame_start (fs6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush4();
        for (int i = 0; i < 16; i++) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (an4 !== 4'hF || cat4 !== 8'hFF || fs4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset4: an=%b cat=%h fs=%b, expected an=1111 cat=ff fs=0", an4, cat4, fs4);
            end
            n_checks++;
            if (an6 !== 6'h3F || cat6 !== 8'hFF || fs6 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset6: an=%b cat=%h fs=%b, expected an=111111 cat=ff fs=0", an6, cat6, fs6);
            end
        end
    endtask

    task automatic test_first_frame();
        rst_n4 = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (an4 !== 4'hF || cat4 !== 8'hFF || fs4 !== (s == 0 && c == 0)) begin
                    n_fail++;
                    $display("FAIL first_frame s=%0d c=%0d: an=%b cat=%h fs=%b, expected dark, fs=%0d",
                             s, c, an4, cat4, fs4, (s == 0 && c == 0));
                end
            end
        end
    endtask

    task automatic test_scan_digits();
        logic [7:0] ecat [4];
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_cat;
        ecat = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        data4 = 16'h1234; dp4 = 4'h0; blank4 = 4'h0; bright4 = 3'd4;
        flush4();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                lit   = 1'b1;
                e_an  = lit ? ~(4'b0001 << s) : 4'hF;
                e_cat = lit ? ecat[s] : 8'hFF;
                n_checks++;
                if (an4 !== e_an || cat4 !== e_cat || fs4 !== (s == 0 && c == 0)) begin
                    n_fail++;
                    $display("FAIL scan_digits s=%0d c=%0d: an=%b cat=%h fs=%b, expected an=%b cat=%h",
                             s, c, an4, cat4, fs4, e_an, e_cat);
                end
            end
        end
    endtask

    task automatic test_bright_one();
        logic [7:0] ecat [4];
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_cat;
        ecat = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        bright4 = 3'd1;
        flush4();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                lit   = (c < 1);
                e_an  = lit ? ~(4'b0001 << s) : 4'hF;
                e_cat = lit ? ecat[s] : 8'hFF;
                n_checks++;
                if (an4 !== e_an || cat4 !== e_cat || fs4 !== (s == 0 && c == 0)) begin
                    n_fail++;
                    $display("FAIL bright_one s=%0d c=%0d: an=%b cat=%h fs=%b, expected an=%b cat=%h",
                             s, c, an4, cat4, fs4, e_an, e_cat);
                end
            end
        end
    endtask

    task automatic test_bright_zero();
        bright4 = 3'd0;
        flush4();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (an4 !== 4'hF || cat4 !== 8'hFF || fs4 !== (s == 0 && c == 0)) begin
                    n_fail++;
                    $display("FAIL bright_zero s=%0d c=%0d: an=%b cat=%h fs=%b, expected dark",
                             s, c, an4, cat4, fs4);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] old_cat [4];
        logic [7:0] new_cat [4];
        logic [3:0] e_an;
        old_cat = '{8'h99, 8'h0D, 8'h25, 8'h9F};
        new_cat = '{8'h85, 8'h63, 8'hC1, 8'h11};
        data4 = 16'h1234; bright4 = 3'd4;
        flush4();
        // Frame in progress: data changes while idx=1 must not show up.
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s == 1 && c == 0) data4 = 16'hABCD;
                step();
                e_an = ~(4'b0001 << s);
                n_checks++;
                if (an4 !== e_an || cat4 !== old_cat[s]) begin
                    n_fail++;
                    $display("FAIL snapshot_old s=%0d c=%0d: an=%b cat=%h, expected an=%b cat=%h",
                             s, c, an4, cat4, e_an, old_cat[s]);
                end
            end
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                e_an = ~(4'b0001 << s);
                n_checks++;
                if (an4 !== e_an || cat4 !== new_cat[s] || fs4 !== (s == 0 && c == 0)) begin
                    n_fail++;
                    $display("FAIL snapshot_new s=%0d c=%0d: an=%b cat=%h fs=%b, expected an=%b cat=%h",
                             s, c, an4, cat4, fs4, e_an, new_cat[s]);
                end
            end
        end
    endtask

    task automatic test_dp_blank();
        logic [7:0] ecat [4];
        logic [3:0] elit;
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_cat;
        ecat = '{8'h02, 8'h03, 8'h03, 8'h03};
`ifdef SEG7_LZB_EN
        elit = 4'b0001;
`else
        elit = 4'b0111;
`endif
        data4 = 16'h0000; dp4 = 4'b0001; blank4 = 4'b1000; bright4 = 3'd4;
        flush4();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                lit   = elit[s];
                e_an  = lit ? ~(4'b0001 << s) : 4'hF;
                e_cat = lit ? ecat[s] : 8'hFF;
                n_checks++;
                if (an4 !== e_an || cat4 !== e_cat) begin
                    n_fail++;
                    $display("FAIL dp_blank s=%0d c=%0d: an=%b cat=%h, expected an=%b cat=%h",
                             s, c, an4, cat4, e_an, e_cat);
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [7:0] ecat [4];
        logic [3:0] elit;
        logic       lit;
        logic [3:0] e_an;
        logic [7:0] e_cat;
        ecat = '{8'h03, 8'h49, 8'h03, 8'h03};
`ifdef SEG7_LZB_EN
        elit = 4'b0011;
`else
        elit = 4'b1111;
`endif
        data4 = 16'h0050; dp4 = 4'b0000; blank4 = 4'b0000; bright4 = 3'd4;
        flush4();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                lit   = elit[s];
                e_an  = lit ? ~(4'b0001 << s) : 4'hF;
                e_cat = lit ? ecat[s] : 8'hFF;
                n_checks++;
                if (an4 !== e_an || cat4 !== e_cat) begin
                    n_fail++;
                    $display("FAIL lzb s=%0d c=%0d: an=%b cat=%h, expected an=%b cat=%h",
                             s, c, an4, cat4, e_an, e_cat);
                end
            end
        end
    endtask

    task automatic test_walk6();
        logic [7:0] ecat [6];
        logic       lit;
        logic [5:0] e_an;
        logic [7:0] e_cat;
        ecat = '{8'hC1, 8'h11, 8'h09, 8'h01, 8'h1F, 8'h41};
        rst_n6 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 6; k++) begin
                step();
                lit   = (f > 0);
                e_an  = lit ? ~(6'b000001 << k) : 6'h3F;
                e_cat = lit ? ecat[k] : 8'hFF;
                n_checks++;
                if (an6 !== e_an || cat6 !== e_cat || fs6 !== (k == 0)) begin
                    n_fail++;
                    $display("FAIL walk6 f=%0d k=%0d: an=%b cat=%h fs=%b, expected an=%b cat=%h fs=%0d",
                             f, k, an6, cat6, fs6, e_an, e_cat, (k == 0));
                end
            end
        end
    endtask

    task automatic test_reset_midframe6();
        logic [7:0] ecat [6];
        logic [5:0] e_an;
        ecat = '{8'hC1, 8'h11, 8'h09, 8'h01, 8'h1F, 8'h41};
        for (int k = 0; k < 3; k++) step();
        rst_n6 = 1'b0;
        step();
        n_checks++;
        if (an6 !== 6'h3F || cat6 !== 8'hFF || fs6 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid6: an=%b cat=%h fs=%b, expected an=111111 cat=ff fs=0", an6, cat6, fs6);
        end
        rst_n6 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (an6 !== 6'h3F || cat6 !== 8'hFF || fs6 !== (k == 0)) begin
                n_fail++;
                $display("FAIL reset_mid6_dark k=%0d: an=%b cat=%h fs=%b, expected dark fs=%0d",
                         k, an6, cat6, fs6, (k == 0));
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            e_an = ~(6'b000001 << k);
            n_checks++;
            if (an6 !== e_an || cat6 !== ecat[k]) begin
                n_fail++;
                $display("FAIL reset_mid6_relit k=%0d: an=%b cat=%h, expected an=%b cat=%h",
                         k, an6, cat6, e_an, ecat[k]);
            end
        end
    endtask

    initial begin
        rst_n4  = 1'b0;
        rst_n6  = 1'b0;
        data4   = 16'h1234;
        dp4     = 4'h0;
        blank4  = 4'h0;
        bright4 = 3'd4;
        data6   = 24'h6789AB;
        dp6     = 6'h00;
        blank6  = 6'h00;
        bright6 = 1'b1;

        test_reset();
        test_first_frame();
        test_scan_digits();
        test_bright_one();
        test_bright_zero();
        test_snapshot();
        test_dp_blank();
        test_lzb();
        test_walk6();
        test_reset_midframe6();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
